// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared definitions for the serial "101" pattern detector.
//   state_t     : FSM state encoding (IDLE, S1, S10, S101), 2 bits wide
//   PATTERN     : the 3-bit pattern being recognised, oldest bit in the MSB
package seq_det_pkg;

    // Each state names the useful prefix of the pattern seen so far.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } state_t;

    // Pattern in arrival order: bit 2 arrives first, bit 0 arrives last.
    localparam logic [2:0] PATTERN = 3'b101;

endpackage : seq_det_pkg

// File: rtl/seq_det.sv
// seq_det
// Serial bit-stream detector for the pattern 1,0,1 (arrival order).
// Raises detect for exactly one cycle after the edge that samples the
// final 1 of a match.
//
// Parameters:
//   OVERLAP : 1 = the trailing 1 of a match may start the next match,
//             0 = the search restarts from scratch after a match
// Ports:
//   clk     : single clock, all state changes on the rising edge
//   reset   : synchronous, active-high; forces the FSM back to IDLE
//   x       : serial data bit, sampled on the rising edge
//   detect  : Moore output, high only while the FSM sits in S101
module seq_det
    import seq_det_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic detect
);

    state_t state;
    state_t next_state;

    // State register. Reset takes priority over whatever x carries on the
    // same edge, so a partially seen prefix is thrown away.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Leaving S101 is the only place the two modes
    // differ: with overlap a following 0 already forms the "1,0" prefix
    // of the next match, without overlap it is treated as a fresh start.
    // The default arm keeps any unexpected encoding from locking up.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: next_state = x ? S1 : IDLE;
            S1:   next_state = x ? S1 : S10;
            S10:  next_state = x ? S101 : IDLE;
            S101: begin
                if (x) begin
                    next_state = S1;
                end else if (OVERLAP != 0) begin
                    next_state = S10;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // detect is a pure decode of the state register, so it carries no
    // combinational path from x and changes only on clock edges.
    assign detect = (state == S101);

endmodule : seq_det

// File: tb/tb_seq_det.sv
// tb_seq_det
// Scoreboard bench for seq_det. Two instances share x/reset, one per
// OVERLAP setting. The driver pushes the expected detect values for each
// edge into a queue; an independent monitor pops and compares one entry
// per cycle, #1 after the rising edge.
module tb_seq_det;
    import seq_det_pkg::*;

    typedef struct {
        bit exp_ovl;
        bit exp_non;
        int idx;
    } exp_t;

    logic clk;
    logic reset;
    logic x;
    logic det_ovl;
    logic det_non;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_idx = 0;

    // Reference model state: last three bits and how many of them are
    // valid since reset (or since the last match, in non-overlap mode).
    logic [2:0] hist_ovl = 3'b000;
    logic [2:0] hist_non = 3'b000;
    int         cnt_ovl = 0;
    int         cnt_non = 0;

    seq_det #(.OVERLAP(1)) dut_ovl (
        .clk    (clk),
        .reset  (reset),
        .x      (x),
        .detect (det_ovl)
    );

    seq_det #(.OVERLAP(0)) dut_non (
        .clk    (clk),
        .reset  (reset),
        .x      (x),
        .detect (det_non)
    );

    // Free-running clock, period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one edge worth of inputs and record what both instances must
    // show after that edge.
    task automatic applyStimulus(input bit xv, input bit rv, input bit e_ovl, input bit e_non);
        exp_t e;
        @(negedge clk);
        x     = xv;
        reset = rv;
        @(posedge clk);
        e.exp_ovl = e_ovl;
        e.exp_non = e_non;
        e.idx     = step_idx;
        step_idx++;
        exp_q.push_back(e);
    endtask

    // Shift-register reference model, independent of the FSM structure.
    task automatic modelStep(input bit xv, input bit rv, output bit e_ovl, output bit e_non);
        if (rv) begin
            hist_ovl = 3'b000;
            hist_non = 3'b000;
            cnt_ovl  = 0;
            cnt_non  = 0;
            e_ovl    = 1'b0;
            e_non    = 1'b0;
        end else begin
            hist_ovl = {hist_ovl[1:0], xv};
            hist_non = {hist_non[1:0], xv};
            if (cnt_ovl < 3) cnt_ovl++;
            if (cnt_non < 3) cnt_non++;
            e_ovl = (cnt_ovl >= 3) && (hist_ovl == PATTERN);
            e_non = (cnt_non >= 3) && (hist_non == PATTERN);
            if (e_non) begin
                cnt_non = 0;
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (det_ovl !== e.exp_ovl) begin
            errors++;
            $display("[TB] FAIL detect_ovl step %0d: got %b expected %b", e.idx, det_ovl, e.exp_ovl);
        end
        checks++;
        if (det_non !== e.exp_non) begin
            errors++;
            $display("[TB] FAIL detect_non step %0d: got %b expected %b", e.idx, det_non, e.exp_non);
        end
    endtask

    // Monitor: one comparison pair per cycle whenever an expectation is
    // pending, sampled away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    // Directed vectors: {x, reset, expected overlap, expected non-overlap}
    localparam int NDIR = 35;
    logic [3:0] dir_vec [NDIR] = '{
        // reset with x=0, then a quiet edge
        4'b0100, 4'b0000,
        // 1,0,1,0,1,1,0,0 : overlap pulses on bits 3 and 5, non-overlap on bit 3 only
        4'b1000, 4'b0000, 4'b1011, 4'b0000, 4'b1010, 4'b1000, 4'b0000, 4'b0000,
        // near misses 1,1,0,0,1,0,0,1 : never asserts
        4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000,
        // 1,0 then reset carrying x=1, then 1 : no pulse; then 0,1 : pulse
        4'b1000, 4'b0000, 4'b1100, 4'b1000, 4'b0000, 4'b1011,
        // reset while in S101 drops detect at that edge
        4'b0100,
        // 1,0,1,0,1,0,1 : overlap every 2 cycles, non-overlap 3 bits apart at best
        4'b1000, 4'b0000, 4'b1011, 4'b0000, 4'b1010, 4'b0000, 4'b1011,
        // S101 then x=1 : both go to S1; then 0,1 completes again for both
        4'b1000, 4'b0000, 4'b1011
    };

    initial begin
        bit eo;
        bit en;
        bit xv;
        bit rv;
        int guard;
        reset = 1'b1;
        x     = 1'b0;

        $display("[TB] directed vectors");
        for (int i = 0; i < NDIR; i++) begin
            applyStimulus(dir_vec[i][3], dir_vec[i][2], dir_vec[i][1], dir_vec[i][0]);
        end

        $display("[TB] random stream against reference model");
        modelStep(1'b0, 1'b1, eo, en);
        applyStimulus(1'b0, 1'b1, eo, en);
        for (int i = 0; i < 1000; i++) begin
            xv = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 63) == 0);
            modelStep(xv, rv, eo, en);
            applyStimulus(xv, rv, eo, en);
        end

        @(negedge clk);
        reset = 1'b0;
        x     = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_det

// File: doc/seq_det.md
# seq_det

Serial bit-stream pattern detector. It samples a 1-bit input `x` on every rising clock edge and raises `detect` for one cycle when the last three sampled bits are `1,0,1` in arrival order. Overlapping occurrences are counted by default. It is a leaf block placed after any serial-input synchroniser and feeds a registered, glitch-free flag to downstream control logic.

## Interface
- `OVERLAP`, default 1: 1 = overlapping detection (trailing `1` of a match starts the next match); 0 = non-overlapping (after a match, the search restarts from scratch).
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: reset is synchronous and active-high; sampled on the `clk` rising edge.
- `x` input 1: serial data bit, sampled on the `clk` rising edge.
- `detect` output 1: registered Moore output; high for one cycle per recognised `101`.

## Operation
- Moore FSM, 2-bit state register, four states:
  - IDLE: no useful prefix.
  - S1: last bit `1`.
  - S10: last bits `1,0`.
  - S101: match complete; `detect` = 1 only in this state.
- Transitions, applied on each rising edge when `reset` = 0:
  - IDLE: x=1 -> S1; x=0 -> IDLE.
  - S1: x=0 -> S10; x=1 -> S1.
  - S10: x=1 -> S101; x=0 -> IDLE.
  - S101 with OVERLAP=1: x=0 -> S10; x=1 -> S1.
  - S101 with OVERLAP=0: x=0 -> IDLE; x=1 -> S1.
- `detect` is decoded as (state == S101). It has no combinational path from `x`.
- Reset has priority over `x`: state -> IDLE, so `detect` = 0 after the edge.
- Illegal or unreachable state encodings (if encoding is not one-hot-complete) return to IDLE on the next edge, with `detect` = 0.
- Bench requirement: `x` must not be X/Z at a sampling edge when `reset` = 0.

## Timing
- Latency: the bit completing `101` is sampled at edge N; `detect` is high from edge N until edge N+1. This is one cycle of latency, with a width of exactly one cycle.
- Back-to-back matches with OVERLAP=1 (input `1,0,1,0,1`): `detect` pulses after the 3rd and 5th bits, with one low cycle between pulses.
- The minimum spacing between pulses is 2 cycles with OVERLAP=1 and 3 cycles with OVERLAP=0.
- Reset asserted mid-match (e.g. in S10) discards the prefix. No `detect` occurs until a full `101` is seen after reset deasserts.
- Reset asserted while in S101: `detect` falls at that same edge.
- Reset value of `detect`: 0.

## Structure
- Shared package `seq_det_pkg` contains:
  - state typedef/encodings IDLE=2'd0, S1=2'd1, S10=2'd2, S101=2'd3;
  - the constant pattern `3'b101` for bench reference models.
- The block is a single module with no sub-modules: one sequential process for the state register and one combinational process for next state. `detect` is a decode of the state.

## Test plan
- Reset: hold `reset`=1 for one edge with x=0 -> state IDLE and `detect`=0 on the next cycle.
- Basic plus overlap, OVERLAP=1, clk period 10:
  - Stimulus: reset edge at t=5; x sampled at edges t=25..95 = `1,0,1,0,1,1,0,0`.
  - Required: `detect`=1 during 45–55 and 65–75, 0 at all other times.
- Non-overlap, OVERLAP=0, same stimulus -> a single pulse at 45–55, with no pulse at 65–75.
- Near-misses: inputs `1,1,0,0,1,0,0,1` -> `detect` never asserts.
- Reset mid-match: input `1,0`, then `reset`=1 for one edge, then `1` -> no pulse. A following `0,1` -> pulse one cycle after the final `1`.
- Randomised 1000-bit stream against a 3-bit shift-register reference model -> `detect` matches the model (delayed one cycle) on every cycle, for both OVERLAP values.
